// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative write-back cache: hit check, LRU update,
// victim writeback and line refill, plus saturating hit/miss/writeback counters.
package cache_control_pkg;
  typedef enum logic {addr_from_cpu = 1'b0, addr_from_array = 1'b1} addrmux_sel_t;
  typedef enum logic {data_from_cpu = 1'b0, data_from_memory = 1'b1} datamux_sel_t;
  typedef enum logic {spec_by_cpu = 1'b0, all_enable = 1'b1} benmux_sel_t;
  typedef enum logic {hit_id = 1'b0, lru_id = 1'b1} waymux_sel_t;
endpackage

module cache_control
  import cache_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic             dirty,
  output addrmux_sel_t     addrmux_sel,
  output datamux_sel_t     datamux_sel,
  output benmux_sel_t      benmux_sel,
  output waymux_sel_t      waymux_sel,
  output logic             data_write,
  output logic             tag_write,
  output logic             valid_write,
  output logic             lru_write,
  output logic             dirty_write,
  output logic             dirty_val,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             refill_r;
  logic [CNT_W-1:0] hit_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;
  logic [CNT_W-1:0] wb_cnt_r;
  logic             hit_evt_s;
  logic             miss_evt_s;
  logic             wb_evt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Only the first COMPARE of a request is an event; the post-refill COMPARE is not.
  assign hit_evt_s  = (state_r == COMPARE) && hit && !refill_r;
  assign miss_evt_s = (state_r == COMPARE) && !hit && !refill_r;
  assign wb_evt_s   = (state_r == WRITEBACK) && pmem_resp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Refill flag marks the COMPARE that follows an ALLOCATE
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_r <= 1'b0;
    end else if (next_state_s == IDLE) begin
      refill_r <= 1'b0;
    end else if ((state_r == ALLOCATE) && pmem_resp) begin
      refill_r <= 1'b1;
    end else begin
      refill_r <= refill_r;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
      wb_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      hit_cnt_r  <= hit_evt_s  ? sat_inc(hit_cnt_r)  : hit_cnt_r;
      miss_cnt_r <= miss_evt_s ? sat_inc(miss_cnt_r) : miss_cnt_r;
      wb_cnt_r   <= wb_evt_s   ? sat_inc(wb_cnt_r)   : wb_cnt_r;
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
  assign wb_count   = wb_cnt_r;

  // Next-state and datapath control decode
  always_comb begin
    next_state_s = state_r;
    addrmux_sel  = addr_from_cpu;
    datamux_sel  = data_from_cpu;
    benmux_sel   = spec_by_cpu;
    waymux_sel   = hit_id;
    data_write   = 1'b0;
    tag_write    = 1'b0;
    valid_write  = 1'b0;
    lru_write    = 1'b0;
    dirty_write  = 1'b0;
    dirty_val    = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    mem_resp     = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_read || mem_write) begin
          next_state_s = COMPARE;
        end else begin
          next_state_s = IDLE;
        end
      end
      COMPARE: begin
        if (hit) begin
          mem_resp     = 1'b1;
          lru_write    = 1'b1;
          waymux_sel   = hit_id;
          next_state_s = IDLE;
          if (mem_write) begin
            data_write  = 1'b1;
            datamux_sel = data_from_cpu;
            benmux_sel  = spec_by_cpu;
            dirty_write = 1'b1;
            dirty_val   = 1'b1;
          end else begin
            data_write  = 1'b0;
          end
        end else begin
          // Point at the victim so the dirty input describes the line to evict.
          waymux_sel = lru_id;
          if (dirty) begin
            next_state_s = WRITEBACK;
          end else begin
            next_state_s = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write  = 1'b1;
        addrmux_sel = addr_from_array;
        waymux_sel  = lru_id;
        if (pmem_resp) begin
          next_state_s = ALLOCATE;
        end else begin
          next_state_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        pmem_read   = 1'b1;
        addrmux_sel = addr_from_cpu;
        waymux_sel  = lru_id;
        if (pmem_resp) begin
          data_write   = 1'b1;
          datamux_sel  = data_from_memory;
          benmux_sel   = all_enable;
          tag_write    = 1'b1;
          valid_write  = 1'b1;
          dirty_write  = 1'b1;
          dirty_val    = 1'b0;
          next_state_s = COMPARE;
        end else begin
          next_state_s = ALLOCATE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: the bench plays the cache datapath and the
// memory, keeping a transaction-level model of tags/valid/dirty/LRU and event counts.
module tb_cache_control;
  import cache_control_pkg::*;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit, dirty, pmem_resp;

  logic mem_resp, data_write, tag_write, valid_write, lru_write, dirty_write, dirty_val;
  logic pmem_read, pmem_write;
  addrmux_sel_t addrmux_sel;
  datamux_sel_t datamux_sel;
  benmux_sel_t  benmux_sel;
  waymux_sel_t  waymux_sel;
  logic [31:0] hit_count, miss_count, wb_count;

  logic mem_resp4, data_write4, tag_write4, valid_write4, lru_write4, dirty_write4, dirty_val4;
  logic pmem_read4, pmem_write4;
  addrmux_sel_t addrmux_sel4;
  datamux_sel_t datamux_sel4;
  benmux_sel_t  benmux_sel4;
  waymux_sel_t  waymux_sel4;
  logic [3:0] hit_count4, miss_count4, wb_count4;

  int checks = 0;
  int errors = 0;

  // Datapath/memory model
  logic [23:0] m_tag[8][2];
  bit          m_valid[8][2];
  bit          m_dirty[8][2];
  bit          m_lru[8];
  int          n_hit, n_miss, n_wb;
  logic [31:0] cur_addr;

  cache_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .dirty(dirty), .addrmux_sel(addrmux_sel), .datamux_sel(datamux_sel),
    .benmux_sel(benmux_sel), .waymux_sel(waymux_sel), .data_write(data_write),
    .tag_write(tag_write), .valid_write(valid_write), .lru_write(lru_write),
    .dirty_write(dirty_write), .dirty_val(dirty_val), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .hit_count(hit_count),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp4),
    .hit(hit), .dirty(dirty), .addrmux_sel(addrmux_sel4), .datamux_sel(datamux_sel4),
    .benmux_sel(benmux_sel4), .waymux_sel(waymux_sel4), .data_write(data_write4),
    .tag_write(tag_write4), .valid_write(valid_write4), .lru_write(lru_write4),
    .dirty_write(dirty_write4), .dirty_val(dirty_val4), .pmem_read(pmem_read4),
    .pmem_write(pmem_write4), .pmem_resp(pmem_resp), .hit_count(hit_count4),
    .miss_count(miss_count4), .wb_count(wb_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lookup(input logic [31:0] a, output bit way);
    int idx;
    idx = int'(a[7:5]);
    way = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[idx][w] && m_tag[idx][w] == a[31:8]) begin
        way = w[0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic drive_dp();
    bit hw, h;
    int idx;
    bit v;
    idx = int'(cur_addr[7:5]);
    h = lookup(cur_addr, hw);
    v = m_lru[idx];
    hit = h;
    dirty = h ? m_dirty[idx][hw] : (m_valid[idx][v] && m_dirty[idx][v]);
  endtask

  function automatic int sat4(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, ":hit_count"}, hit_count, n_hit);
    chk({tag, ":miss_count"}, miss_count, n_miss);
    chk({tag, ":wb_count"}, wb_count, n_wb);
    chk({tag, ":hit_count4"}, hit_count4, sat4(n_hit));
    chk({tag, ":miss_count4"}, miss_count4, sat4(n_miss));
    chk({tag, ":wb_count4"}, wb_count4, sat4(n_wb));
  endtask

  // One complete CPU access; expected cycle schedule derived from the cache model.
  task automatic access(input logic [31:0] a, input bit wr, input int rlat, input int wlat);
    int idx, al_start, fin, c;
    bit h, hw, v, wb, done, in_wb, in_al, fway;
    idx = int'(a[7:5]);
    h = lookup(a, hw);
    v = m_lru[idx];
    wb = !h && m_valid[idx][v] && m_dirty[idx][v];
    al_start = wb ? (3 + wlat) : 2;
    fin = h ? 1 : (al_start + rlat + 1);
    c = 0;
    done = 1'b0;
    @(negedge clk);
    cur_addr = a;
    mem_read = !wr;
    mem_write = wr;
    pmem_resp = 1'b0;
    drive_dp();
    while (!done && c < fin + 4) begin
      @(posedge clk);
      c++;
      if (!h && c == al_start + rlat + 1) begin
        m_tag[idx][v] = a[31:8];
        m_valid[idx][v] = 1'b1;
        m_dirty[idx][v] = 1'b0;
      end
      @(negedge clk);
      drive_dp();
      pmem_resp = !h && ((wb && c == al_start - 1) || c == al_start + rlat);
      #1;
      in_wb = wb && c >= 2 && c < al_start;
      in_al = !h && c >= al_start && c <= al_start + rlat;
      chk("mem_resp", mem_resp, c == fin);
      chk("pmem_write", pmem_write, in_wb);
      chk("pmem_read", pmem_read, in_al);
      chk("pmem_exclusive", pmem_read && pmem_write, 1'b0);
      if (c == fin) begin
        chk("hit_lru_write", lru_write, 1'b1);
        chk("hit_waymux", waymux_sel, hit_id);
        chk("hit_data_write", data_write, wr);
        chk("hit_dirty_write", dirty_write, wr);
        chk("hit_dirty_val", dirty_val, wr);
        chk("hit_tag_write", tag_write, 1'b0);
        if (wr) begin
          chk("hit_benmux", benmux_sel, spec_by_cpu);
          chk("hit_datamux", datamux_sel, data_from_cpu);
        end
        done = 1'b1;
      end else if (c == 1) begin
        chk("miss_waymux", waymux_sel, lru_id);
        chk("miss_lru_write", lru_write, 1'b0);
        chk("miss_data_write", data_write, 1'b0);
      end else if (in_wb) begin
        chk("wb_addrmux", addrmux_sel, addr_from_array);
        chk("wb_waymux", waymux_sel, lru_id);
        chk("wb_data_write", data_write, 1'b0);
      end else if (in_al) begin
        chk("al_addrmux", addrmux_sel, addr_from_cpu);
        chk("al_waymux", waymux_sel, lru_id);
        chk("al_data_write", data_write, pmem_resp);
        chk("al_tag_write", tag_write, pmem_resp);
        chk("al_valid_write", valid_write, pmem_resp);
        chk("al_dirty_write", dirty_write, pmem_resp);
        chk("al_dirty_val", dirty_val, 1'b0);
        if (pmem_resp) begin
          chk("al_datamux", datamux_sel, data_from_memory);
          chk("al_benmux", benmux_sel, all_enable);
        end
      end
    end
    chk("access_timeout", done, 1'b1);
    @(posedge clk);
    fway = h ? hw : v;
    m_lru[idx] = ~fway;
    if (wr) m_dirty[idx][fway] = 1'b1;
    if (h) n_hit++; else n_miss++;
    if (wb) n_wb++;
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    #1;
    chk("idle_mem_resp", mem_resp, 1'b0);
    check_counters("post_access");
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      m_lru[i] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[i][w] = 1'b0;
        m_dirty[i][w] = 1'b0;
        m_tag[i][w] = 24'h0;
      end
    end
    n_hit = 0; n_miss = 0; n_wb = 0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0;
    pmem_resp = 1'b0; cur_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_mem_resp", mem_resp, 1'b0);
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_pmem_write", pmem_write, 1'b0);
    chk("reset_waymux", waymux_sel, hit_id);
    check_counters("reset");

    // Directed: cold read, repeat hit, write hit, fill index 2, dirty eviction
    access(32'h0000_0040, 1'b0, 2, 0);
    access(32'h0000_0040, 1'b0, 0, 0);
    access(32'h0000_0044, 1'b1, 0, 0);
    access(32'h0001_0040, 1'b0, 1, 0);
    access(32'h0002_0040, 1'b0, 1, 2);
    chk("wb_count_after_evict", wb_count, 32'd1);

    // Make both ways of index 2 dirty, then reset mid-writeback
    access(32'h0002_0040, 1'b1, 0, 0);
    access(32'h0001_0040, 1'b1, 0, 0);
    @(negedge clk);
    cur_addr = 32'h0000_0040;
    mem_read = 1'b1;
    drive_dp();
    chk("pre_rst_miss", hit, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_waymux", waymux_sel, lru_id);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_pmem_write", pmem_write, 1'b1);
    rst = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    n_hit = 0; n_miss = 0; n_wb = 0;
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_addrmux", addrmux_sel, addr_from_cpu);
    check_counters("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("late_resp_pmem_read", pmem_read, 1'b0);
    chk("late_resp_tag_write", tag_write, 1'b0);
    chk("late_resp_data_write", data_write, 1'b0);
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("late_resp_pmem_write", pmem_write, 1'b0);
    chk("late_resp_mem_resp", mem_resp, 1'b0);
    check_counters("late_resp");
    access(32'h0000_0040, 1'b0, 1, 1);

    // Saturation of the 4-bit instance
    for (int i = 0; i < 17; i++) access(32'h0000_0040, 1'b0, 0, 0);
    chk("hit_count4_saturated", hit_count4, 4'hF);

    // Randomized accesses over a small address pool to mix hits, misses and evictions
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      access(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
